// File: rtl/picnic_stage_sequencer.sv
// rtl/picnic_stage_sequencer.sv - ascending-order stage controller with skip mask, per-stage watchdog and abort
// Each enabled stage gets a start level until its end level returns; one idle GAP cycle separates stages.
module picnic_stage_sequencer #(
  parameter int N_STAGES  = 6,
  parameter int TIMEOUT_W = 16,
  parameter int IDX_W     = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 seq_start,
  input  logic                 abort,
  input  logic [N_STAGES-1:0]  stage_en_mask,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  input  logic [N_STAGES-1:0]  stage_end,
  output logic [N_STAGES-1:0]  stage_start,
  output logic [IDX_W-1:0]     cur_stage,
  output logic [N_STAGES-1:0]  stage_done_mask,
  output logic                 seq_busy,
  output logic                 seq_done,
  output logic                 seq_err,
  output logic [IDX_W-1:0]     err_stage
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_DONE, S_ERR} state_t;

  localparam logic [N_STAGES-1:0] ONE = N_STAGES'(1);

  state_t               state;
  logic [N_STAGES-1:0]  mask_q;
  logic [TIMEOUT_W-1:0] limit_q;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic [IDX_W-1:0]     first_idx;
  logic [IDX_W-1:0]     next_idx;
  logic                 have_next;
  logic                 cur_end;
  logic                 wd_expire;

  always_comb begin
    first_idx = '0;
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      if (stage_en_mask[i]) first_idx = IDX_W'(i);
    end
  end

  // Lowest enabled stage strictly above the current one.
  always_comb begin
    next_idx  = '0;
    have_next = 1'b0;
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(cur_stage))) begin
        next_idx  = IDX_W'(i);
        have_next = 1'b1;
      end
    end
  end

  assign cur_end   = stage_end[cur_stage];
  assign wd_expire = (limit_q != '0) && (wd_cnt == limit_q - TIMEOUT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      mask_q          <= '0;
      limit_q         <= '0;
      wd_cnt          <= '0;
      stage_start     <= '0;
      cur_stage       <= '0;
      stage_done_mask <= '0;
      seq_busy        <= 1'b0;
      seq_done        <= 1'b0;
      seq_err         <= 1'b0;
      err_stage       <= '0;
    end else if (abort && (state != S_IDLE)) begin
      // Completed-stage record survives so software can see how far the run got.
      state       <= S_IDLE;
      stage_start <= '0;
      seq_busy    <= 1'b0;
      seq_done    <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (seq_start) begin
            stage_done_mask <= '0;
            if (stage_en_mask != '0) begin
              mask_q      <= stage_en_mask;
              limit_q     <= timeout_limit;
              cur_stage   <= first_idx;
              stage_start <= ONE << first_idx;
              wd_cnt      <= '0;
              seq_busy    <= 1'b1;
              state       <= S_RUN;
            end else begin
              seq_done <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (cur_end) begin
            stage_start                <= '0;
            stage_done_mask[cur_stage] <= 1'b1;
            if (have_next) begin
              cur_stage <= next_idx;
              state     <= S_GAP;
            end else begin
              seq_busy <= 1'b0;
              seq_done <= 1'b1;
              state    <= S_DONE;
            end
          end else if (wd_expire) begin
            stage_start <= '0;
            err_stage   <= cur_stage;
            seq_busy    <= 1'b0;
            seq_err     <= 1'b1;
            state       <= S_ERR;
          end else begin
            wd_cnt <= wd_cnt + TIMEOUT_W'(1);
          end
        end
        S_GAP: begin
          stage_start <= ONE << cur_stage;
          wd_cnt      <= '0;
          state       <= S_RUN;
        end
        S_DONE, S_ERR: begin
          if (!seq_start) begin
            seq_done <= 1'b0;
            seq_err  <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picnic_stage_sequencer.sv
// tb/tb_picnic_stage_sequencer.sv - directed self-checking bench for picnic_stage_sequencer
module tb_picnic_stage_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        seq_start;
  logic        abort;
  logic [5:0]  stage_en_mask;
  logic [15:0] timeout_limit;
  logic [5:0]  stage_end;
  logic [5:0]  stage_start;
  logic [2:0]  cur_stage;
  logic [5:0]  stage_done_mask;
  logic        seq_busy;
  logic        seq_done;
  logic        seq_err;
  logic [2:0]  err_stage;

  int n_cmp = 0;
  int n_bad = 0;
  int hi_cnt[6];
  int end_delay[6];
  bit auto_end;

  picnic_stage_sequencer #(.N_STAGES(6), .TIMEOUT_W(16)) dut (
    .clk(clk), .reset(reset), .seq_start(seq_start), .abort(abort),
    .stage_en_mask(stage_en_mask), .timeout_limit(timeout_limit),
    .stage_end(stage_end), .stage_start(stage_start), .cur_stage(cur_stage),
    .stage_done_mask(stage_done_mask), .seq_busy(seq_busy), .seq_done(seq_done),
    .seq_err(seq_err), .err_stage(err_stage)
  );

  always #5 clk = ~clk;

  // Sub-block model: stage i raises its end level once its start has been seen high end_delay[i] times.
  task automatic step;
    @(negedge clk);
    if (auto_end) begin
      for (int i = 0; i < 6; i++) begin
        if (stage_start[i]) begin
          hi_cnt[i]++;
          if (end_delay[i] != 0 && hi_cnt[i] >= end_delay[i]) stage_end[i] = 1'b1;
        end else begin
          hi_cnt[i] = 0;
          stage_end[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic set_delays(input int d);
    for (int i = 0; i < 6; i++) begin
      end_delay[i] = d;
      hi_cnt[i] = 0;
    end
  endtask

  task automatic idle_out;
    seq_start = 1'b0;
    abort = 1'b0;
    step;
    step;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step;
    step;
    n_cmp++;
    if ({stage_start, cur_stage, stage_done_mask, seq_busy, seq_done, seq_err, err_stage} !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected 0",
               {stage_start, cur_stage, stage_done_mask, seq_busy, seq_done, seq_err, err_stage});
    end
    reset = 1'b0;
    step;
  endtask

  task automatic test_full_sequence;
    int rise[6];
    int hcnt[6];
    int done_t;
    int multi;
    int busy_at_done;
    done_t = -1;
    multi = 0;
    busy_at_done = -1;
    for (int i = 0; i < 6; i++) begin
      rise[i] = -1;
      hcnt[i] = 0;
    end
    stage_en_mask = 6'b111111;
    timeout_limit = 16'd0;
    set_delays(3);
    seq_start = 1'b1;
    for (int t = 0; t < 40 && done_t < 0; t++) begin
      step;
      if ($countones(stage_start) > 1) multi++;
      for (int i = 0; i < 6; i++) begin
        if (stage_start[i]) begin
          if (rise[i] < 0) rise[i] = t;
          hcnt[i]++;
        end
      end
      if (seq_done) begin
        done_t = t;
        busy_at_done = int'(seq_busy);
      end
    end
    n_cmp++;
    if (done_t !== 23) begin n_bad++; $display("FAIL full_done_latency: got %0d expected 23", done_t); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (rise[i] !== 4 * i) begin n_bad++; $display("FAIL full_rise_stage%0d: got %0d expected %0d", i, rise[i], 4 * i); end
      n_cmp++;
      if (hcnt[i] !== 3) begin n_bad++; $display("FAIL full_width_stage%0d: got %0d expected 3", i, hcnt[i]); end
    end
    n_cmp++;
    if (multi !== 0) begin n_bad++; $display("FAIL full_onehot: got %0d multi-start cycles expected 0", multi); end
    n_cmp++;
    if (busy_at_done !== 0) begin n_bad++; $display("FAIL full_busy_at_done: got %0d expected 0", busy_at_done); end
    n_cmp++;
    if (stage_done_mask !== 6'b111111) begin n_bad++; $display("FAIL full_done_mask: got %b expected 111111", stage_done_mask); end
    idle_out;
  endtask

  task automatic test_skip;
    int order[$];
    int exp_order[3];
    logic [5:0] seen;
    int done_t;
    logic [5:0] prev;
    exp_order = '{0, 3, 5};
    seen = '0;
    prev = '0;
    done_t = -1;
    stage_en_mask = 6'b101001;
    timeout_limit = 16'd0;
    set_delays(3);
    seq_start = 1'b1;
    for (int t = 0; t < 40 && done_t < 0; t++) begin
      step;
      seen = seen | stage_start;
      if (stage_start != 6'b0 && prev == 6'b0) order.push_back(int'(cur_stage));
      prev = stage_start;
      if (seq_done) done_t = t;
    end
    n_cmp++;
    if (seen !== 6'b101001) begin n_bad++; $display("FAIL skip_started: got %b expected 101001", seen); end
    n_cmp++;
    if (order.size() !== 3) begin n_bad++; $display("FAIL skip_order_len: got %0d expected 3", order.size()); end
    for (int i = 0; i < 3 && i < order.size(); i++) begin
      n_cmp++;
      if (order[i] !== exp_order[i]) begin n_bad++; $display("FAIL skip_cur_stage%0d: got %0d expected %0d", i, order[i], exp_order[i]); end
    end
    n_cmp++;
    if (done_t !== 11) begin n_bad++; $display("FAIL skip_done_latency: got %0d expected 11", done_t); end
    n_cmp++;
    if (stage_done_mask !== 6'b101001) begin n_bad++; $display("FAIL skip_done_mask: got %b expected 101001", stage_done_mask); end
    idle_out;
  endtask

  task automatic test_mask_zero;
    int starts;
    stage_en_mask = 6'b000000;
    seq_start = 1'b1;
    step;
    n_cmp++;
    if ({seq_done, seq_busy} !== 2'b10) begin n_bad++; $display("FAIL zero_mask_done: got done/busy %b expected 10", {seq_done, seq_busy}); end
    starts = 0;
    for (int t = 0; t < 3; t++) begin
      if (stage_start != 6'b0 || !seq_done) starts++;
      step;
    end
    n_cmp++;
    if (starts !== 0) begin n_bad++; $display("FAIL zero_mask_hold: got %0d bad cycles expected 0", starts); end
    idle_out;
  endtask

  task automatic test_watchdog;
    int hcnt2;
    int rise2;
    int err_t;
    logic [5:0] start_at_err;
    logic [2:0] es_at_err;
    hcnt2 = 0;
    rise2 = -1;
    err_t = -1;
    start_at_err = 6'h3F;
    es_at_err = 3'd7;
    stage_en_mask = 6'b000111;
    timeout_limit = 16'd5;
    set_delays(3);
    end_delay[2] = 0;
    seq_start = 1'b1;
    for (int t = 0; t < 40 && err_t < 0 && !seq_done; t++) begin
      step;
      if (stage_start[2]) begin
        if (rise2 < 0) rise2 = t;
        hcnt2++;
      end
      if (seq_err) begin
        err_t = t;
        start_at_err = stage_start;
        es_at_err = err_stage;
      end
    end
    n_cmp++;
    if (rise2 !== 8) begin n_bad++; $display("FAIL wd_rise_stage2: got %0d expected 8", rise2); end
    n_cmp++;
    if (hcnt2 !== 5) begin n_bad++; $display("FAIL wd_width_stage2: got %0d expected 5", hcnt2); end
    n_cmp++;
    if (err_t !== 13) begin n_bad++; $display("FAIL wd_err_time: got %0d expected 13", err_t); end
    n_cmp++;
    if (es_at_err !== 3'd2) begin n_bad++; $display("FAIL wd_err_stage: got %0d expected 2", es_at_err); end
    n_cmp++;
    if (start_at_err !== 6'b0) begin n_bad++; $display("FAIL wd_starts_low: got %b expected 000000", start_at_err); end
    step;
    step;
    n_cmp++;
    if ({seq_err, seq_done, seq_busy} !== 3'b100) begin n_bad++; $display("FAIL wd_err_held: got err/done/busy %b expected 100", {seq_err, seq_done, seq_busy}); end
    seq_start = 1'b0;
    step;
    n_cmp++;
    if (seq_err !== 1'b0) begin n_bad++; $display("FAIL wd_err_clear: got %b expected 0", seq_err); end
    idle_out;
  endtask

  task automatic test_watchdog_boundary;
    int hcnt2;
    int rise3;
    int done_t;
    int err_seen;
    hcnt2 = 0;
    rise3 = -1;
    done_t = -1;
    err_seen = 0;
    stage_en_mask = 6'b001111;
    timeout_limit = 16'd5;
    set_delays(3);
    end_delay[2] = 5;
    seq_start = 1'b1;
    for (int t = 0; t < 40 && done_t < 0 && err_seen == 0; t++) begin
      step;
      if (stage_start[2]) hcnt2++;
      if (stage_start[3] && rise3 < 0) rise3 = t;
      if (seq_err) err_seen = 1;
      if (seq_done) done_t = t;
    end
    n_cmp++;
    if (err_seen !== 0) begin n_bad++; $display("FAIL wdb_no_err: got %0d expected 0", err_seen); end
    n_cmp++;
    if (hcnt2 !== 5) begin n_bad++; $display("FAIL wdb_width_stage2: got %0d expected 5", hcnt2); end
    n_cmp++;
    if (rise3 !== 14) begin n_bad++; $display("FAIL wdb_rise_stage3: got %0d expected 14", rise3); end
    n_cmp++;
    if (done_t !== 17) begin n_bad++; $display("FAIL wdb_done_time: got %0d expected 17", done_t); end
    n_cmp++;
    if (stage_done_mask !== 6'b001111) begin n_bad++; $display("FAIL wdb_done_mask: got %b expected 001111", stage_done_mask); end
    idle_out;
  endtask

  task automatic test_abort;
    int found;
    found = 0;
    stage_en_mask = 6'b111111;
    timeout_limit = 16'd0;
    set_delays(3);
    seq_start = 1'b1;
    for (int t = 0; t < 40 && found == 0; t++) begin
      step;
      if (stage_start[3]) found = 1;
    end
    n_cmp++;
    if (found !== 1) begin n_bad++; $display("FAIL abort_reach_stage3: got %0d expected 1", found); end
    abort = 1'b1;
    seq_start = 1'b0;
    step;
    n_cmp++;
    if ({stage_start, seq_busy, seq_done, seq_err} !== 9'b0) begin n_bad++; $display("FAIL abort_outputs: got %b expected 0", {stage_start, seq_busy, seq_done, seq_err}); end
    n_cmp++;
    if (stage_done_mask !== 6'b000111) begin n_bad++; $display("FAIL abort_done_mask: got %b expected 000111", stage_done_mask); end
    abort = 1'b0;
    seq_start = 1'b1;
    step;
    n_cmp++;
    if (stage_start !== 6'b000001) begin n_bad++; $display("FAIL abort_then_idle: got %b expected 000001", stage_start); end
    abort = 1'b1;
    seq_start = 1'b0;
    step;
    idle_out;
  endtask

  task automatic test_abort_with_end;
    int found;
    found = 0;
    stage_en_mask = 6'b111111;
    timeout_limit = 16'd0;
    set_delays(3);
    seq_start = 1'b1;
    for (int t = 0; t < 40 && found == 0; t++) begin
      step;
      if (stage_end[1]) found = 1;
    end
    abort = 1'b1;
    seq_start = 1'b0;
    step;
    n_cmp++;
    if (stage_done_mask !== 6'b000001) begin n_bad++; $display("FAIL abort_end_done_mask: got %b expected 000001", stage_done_mask); end
    n_cmp++;
    if ({stage_start, seq_busy} !== 7'b0) begin n_bad++; $display("FAIL abort_end_outputs: got %b expected 0", {stage_start, seq_busy}); end
    idle_out;
  endtask

  task automatic test_hold_restart;
    int done_t;
    int bad;
    done_t = -1;
    bad = 0;
    stage_en_mask = 6'b000011;
    timeout_limit = 16'd0;
    set_delays(3);
    seq_start = 1'b1;
    for (int t = 0; t < 40 && done_t < 0; t++) begin
      step;
      if (seq_done) done_t = t;
    end
    n_cmp++;
    if (done_t !== 7) begin n_bad++; $display("FAIL hold_done_time: got %0d expected 7", done_t); end
    for (int t = 0; t < 10; t++) begin
      step;
      if (!seq_done || seq_busy || stage_start != 6'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin n_bad++; $display("FAIL hold_no_restart: got %0d bad cycles expected 0", bad); end
    seq_start = 1'b0;
    step;
    n_cmp++;
    if (seq_done !== 1'b0) begin n_bad++; $display("FAIL hold_done_clear: got %b expected 0", seq_done); end
    seq_start = 1'b1;
    step;
    n_cmp++;
    if ({stage_start, stage_done_mask} !== 12'b000001_000000) begin n_bad++; $display("FAIL restart_first: got %b expected 000001000000", {stage_start, stage_done_mask}); end
    done_t = -1;
    for (int t = 0; t < 40 && done_t < 0; t++) begin
      step;
      if (seq_done) done_t = t;
    end
    n_cmp++;
    if (stage_done_mask !== 6'b000011) begin n_bad++; $display("FAIL restart_done_mask: got %b expected 000011", stage_done_mask); end
    idle_out;
  endtask

  task automatic test_reset_midrun;
    int found;
    found = 0;
    stage_en_mask = 6'b111111;
    timeout_limit = 16'd0;
    set_delays(3);
    seq_start = 1'b1;
    for (int t = 0; t < 40 && found == 0; t++) begin
      step;
      if (stage_start[1]) found = 1;
    end
    reset = 1'b1;
    step;
    n_cmp++;
    if ({stage_start, cur_stage, stage_done_mask, seq_busy, seq_done, seq_err, err_stage} !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_midrun_outputs: got %h expected 0",
               {stage_start, cur_stage, stage_done_mask, seq_busy, seq_done, seq_err, err_stage});
    end
    reset = 1'b0;
    seq_start = 1'b0;
    auto_end = 1'b0;
    stage_end = 6'b111111;
    step;
    step;
    step;
    n_cmp++;
    if ({stage_start, stage_done_mask, seq_busy, seq_done} !== 14'b0) begin n_bad++; $display("FAIL reset_stray_end: got %b expected 0", {stage_start, stage_done_mask, seq_busy, seq_done}); end
    stage_end = 6'b0;
    auto_end = 1'b1;
    step;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    seq_start = 1'b0;
    abort = 1'b0;
    stage_en_mask = 6'b0;
    timeout_limit = 16'd0;
    stage_end = 6'b0;
    auto_end = 1'b1;
    set_delays(3);
    test_reset;
    test_full_sequence;
    test_skip;
    test_mask_zero;
    test_watchdog;
    test_watchdog_boundary;
    test_abort;
    test_abort_with_end;
    test_hold_restart;
    test_reset_midrun;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/picnic_stage_sequencer.md
# picnic_stage_sequencer

Parametrised stage controller for the Picnic-on-SM4 signing datapath. It drives up to N_STAGES sub-blocks (seed tree, tape setup, aux computation, commitment, MPC simulation, Ch/Cv hashing, …) through a start/end level handshake in ascending index order. A run-time mask skips stages, a per-stage watchdog flags hung sub-blocks, and an abort input cancels a run. Signing-step top levels instantiate it in place of their hand-written state chains.

## Interface

- N_STAGES, default 6: number of sequenced stages, 1..32.
- TIMEOUT_W, default 16: width of the watchdog counter and timeout limit.
- IDX_W, default $clog2(N_STAGES) (min 1): width of stage index outputs.

Reset is synchronous and active-high; `reset` is sampled only on the rising edge of `clk`.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- seq_start  in  1  level request; a run begins when high in IDLE.
- abort  in  1  cancels an active run.
- stage_en_mask  in  N_STAGES  bit i=1 runs stage i; latched at run start.
- timeout_limit  in  TIMEOUT_W  maximum cycles per stage; 0 disables the watchdog; latched at run start.
- stage_end  in  N_STAGES  per-stage completion level from the sub-blocks.
- stage_start  out  N_STAGES  per-stage start level; at most one bit is high.
- cur_stage  out  IDX_W  index of the active stage.
- stage_done_mask  out  N_STAGES  stages completed in this run.
- seq_busy  out  1  high in RUN or GAP.
- seq_done  out  1  run completed.
- seq_err  out  1  watchdog fired.
- err_stage  out  IDX_W  stage that timed out.

## Operation

- States: IDLE, RUN, GAP, DONE, ERR. All outputs are registered.
- IDLE
  - With seq_start=1 and the sampled mask nonzero: latch mask and limit, set cur_stage to the lowest enabled index, clear stage_done_mask, go to RUN.
  - With seq_start=1 and mask=0: go directly to DONE.
- RUN
  - stage_start[cur_stage]=1. Watchdog counter cleared on RUN entry, incremented each RUN cycle.
  - stage_end[cur_stage]=1: drop stage_start, set stage_done_mask[cur_stage]. If a higher enabled stage remains, load cur_stage with the next enabled index via a combinational priority search and go to GAP; otherwise go to DONE.
  - stage_end bits for other stages are ignored.
- GAP: one cycle with all stage_start low so sub-blocks see a falling edge, then RUN.
- Watchdog: with limit≠0, a counter equal to limit−1 in RUN with no stage_end goes to ERR. err_stage=cur_stage; stage_start goes low. If stage_end and expiry occur in the same cycle, stage_end wins.
- DONE / ERR
  - seq_done or seq_err is held while seq_start=1.
  - When seq_start=0, go to IDLE; the flag clears on the same edge.
  - A new run needs seq_start to fall and then rise again, so there is no auto-restart.
- abort in RUN, GAP, DONE or ERR: next state IDLE. stage_start, seq_busy, seq_done and seq_err clear; stage_done_mask is kept. abort has priority over stage_end and the watchdog; it is ignored in IDLE.
- Reset values: every output is 0 and the state is IDLE. Reset mid-run clears everything on the next edge, including a stage_start that is high.

## Timing

- seq_start sampled high at edge k: stage_start[first] is high from after edge k.
- stage_end sampled at edge m: stage_start low after m; next stage_start high after m+1 (one GAP cycle).
- Last stage_end at edge m: seq_done high after m, seq_busy low after m.
- Watchdog with limit L: ERR is entered at the L-th RUN edge without an end, counting from stage_start rise.
- Skipped stages cost 0 cycles.
- Per-stage overhead: 1 cycle (GAP).

## Test plan

- Full sequence: N=6, mask=6'b111111, limit=0, each stage_end raised 3 cycles after its start. Required: starts pulse in order 0..5, each 3 cycles high with 1 cycle gaps; seq_done rises 23 cycles after seq_start sampled; stage_done_mask=6'b111111.
- Skip: mask=6'b101001. Required: only stages 0, 3, 5 start; cur_stage takes the values 0→3→5; stage_done_mask=6'b101001. mask=0 gives seq_done on the next cycle with no starts.
- Watchdog: limit=5, stage 2 never ends. Required: stage_start[2] high for exactly 5 cycles, then seq_err=1, err_stage=2, all starts 0. stage_end[2] coincident with the 5th cycle instead yields normal advance.
- Abort: abort during stage 3's RUN. Required: next cycle state IDLE, all starts 0, seq_busy 0, stage_done_mask=6'b000111. abort coincident with stage_end is also covered.
- Hold/restart: seq_start kept high after done. Required: seq_done stays 1 and no second run. Dropping seq_start clears seq_done; raising it again runs a fresh sequence.
- Reset mid-run: reset asserted while stage_start[1]=1. Required: all outputs 0 after that edge; a stray stage_end afterwards is ignored.
